// File: rtl/axil_gpio_pkg.sv
// axil_gpio_pkg: shared definitions for the AXI4-Lite GPIO responder.
//   - Register indices (address bits [4:2]) of the GPIO register map
//   - AXI response codes
//   - Write/read channel FSM state types
//   - strb_to_mask: expands a 4-bit WSTRB into a 32-bit bit mask
package axil_gpio_pkg;

  localparam logic [2:0] REG_OUT   = 3'd0;  // 0x00 rw
  localparam logic [2:0] REG_OE    = 3'd1;  // 0x04 rw
  localparam logic [2:0] REG_IN    = 3'd2;  // 0x08 ro
  localparam logic [2:0] REG_SET   = 3'd3;  // 0x0C w1s on OUT
  localparam logic [2:0] REG_CLR   = 3'd4;  // 0x10 w1c on OUT
  localparam logic [2:0] REG_ISTAT = 3'd5;  // 0x14 w1c
  localparam logic [2:0] REG_IMASK = 3'd6;  // 0x18 rw

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axil_gpio_slave_if.sv
// axil_gpio_slave_if: AXI4-Lite bus bundle between the interconnect master
// and the GPIO responder.
//   AW: S_AWADDR/S_AWVALID/S_AWREADY   W: S_WDATA/S_WSTRB/S_WVALID/S_WREADY
//   B : S_BRESP/S_BVALID/S_BREADY      AR: S_ARADDR/S_ARVALID/S_ARREADY
//   R : S_RDATA/S_RRESP/S_RVALID/S_RREADY
// Modports: slave (responder side), master (initiator side).
interface axil_gpio_slave_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ADDR_W-1:0] S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: GPIO_W-wide two-flop synchronizer for asynchronous pin inputs.
//   clk in  : sampling clock
//   rst in  : synchronous active-high reset, clears both stages
//   d   in  : asynchronous pin values
//   q   out : synchronized values (2 cycles latency)
module gpio_in_sync #(
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] d,
  output logic [GPIO_W-1:0] q
);
  logic [GPIO_W-1:0] meta_q, meta_d;
  logic [GPIO_W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/axil_gpio_slave.sv
// axil_gpio_slave: AXI4-Lite responder for the SoC GPIO block.
//   aclk/areset : clock, synchronous active-high reset
//   s           : AXI4-Lite slave bus (axil_gpio_slave_if.slave)
//   gpio_in     : asynchronous pin inputs (2-flop synchronized)
//   gpio_out    : output data register
//   gpio_oe     : output enable register (1 = drive)
//   irq         : level interrupt
// Register map (addr[4:2]): OUT, OE, IN, OUT_SET, OUT_CLR, IRQ_STAT, IRQ_MASK;
// index 7 is unmapped (SLVERR). One outstanding transaction per direction.
// Build option: define GPIO_IRQ_EN to enable edge-detect interrupt logic;
// otherwise IRQ_STAT/IRQ_MASK read 0, ignore writes, and irq is tied 0.
module axil_gpio_slave
  import axil_gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  axil_gpio_slave_if.slave  s,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  logic [GPIO_W-1:0] sync_in;

  gpio_in_sync #(.GPIO_W(GPIO_W)) u_sync (
    .clk (aclk),
    .rst (areset),
    .d   (gpio_in),
    .q   (sync_in)
  );

  // Write channel state
  w_state_t          w_state_q, w_state_d;
  logic              aw_full_q, aw_full_d;
  logic [2:0]        aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [GPIO_W-1:0] w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [1:0]        bresp_q, bresp_d;

  // Register file
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] oe_q, oe_d;

  // Read channel state
  r_state_t          r_state_q, r_state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic              aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, commit;
  logic [2:0]        wr_idx;
  logic [GPIO_W-1:0] wr_data, wr_mask, wr_bits;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_mask32;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [GPIO_W-1:0] mask_q, mask_d;
  logic [GPIO_W-1:0] stat_clr, edges;
  logic              irq_q, irq_d;

  // A pin edge in the same cycle as a W1C of that bit wins (OR after clear).
  always_comb begin
    prev_d = sync_in;
    edges  = sync_in ^ prev_q;
    stat_d = (stat_q & ~stat_clr) | edges;
    irq_d  = |(stat_q & mask_q);
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign aw_addr = s.S_AWADDR;
  assign ar_addr = s.S_ARADDR;

  // Write path: AW and W are buffered independently; the commit uses the
  // buffered copy or the live bus value, whichever handshake came last.
  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    out_d     = out_q;
    oe_d      = oe_q;
`ifdef GPIO_IRQ_EN
    mask_d    = mask_q;
    stat_clr  = '0;
`endif

    aw_rdy = !areset && (w_state_q == W_COLLECT) && !aw_full_q;
    w_rdy  = !areset && (w_state_q == W_COLLECT) && !w_full_q;
    aw_hs  = s.S_AWVALID && aw_rdy;
    w_hs   = s.S_WVALID && w_rdy;

    wr_idx    = aw_full_q ? aw_idx_q : aw_addr[4:2];
    wr_data   = w_full_q ? w_data_q : s.S_WDATA[GPIO_W-1:0];
    wr_strb   = w_full_q ? w_strb_q : s.S_WSTRB;
    wr_mask32 = strb_to_mask(wr_strb);
    wr_mask   = wr_mask32[GPIO_W-1:0];
    wr_bits   = wr_data & wr_mask;
    commit    = (w_state_q == W_COLLECT) && (aw_full_q || aw_hs) && (w_full_q || w_hs);

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aw_addr[4:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s.S_WDATA[GPIO_W-1:0];
      w_strb_d = s.S_WSTRB;
    end

    case (w_state_q)
      W_COLLECT: begin
        if (commit) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          w_state_d = W_RESP;
          bresp_d   = RESP_OKAY;
          case (wr_idx)
            REG_OUT:   out_d = (out_q & ~wr_mask) | wr_bits;
            REG_OE:    oe_d  = (oe_q & ~wr_mask) | wr_bits;
            REG_IN:    ;
            REG_SET:   out_d = out_q | wr_bits;
            REG_CLR:   out_d = out_q & ~wr_bits;
`ifdef GPIO_IRQ_EN
            REG_ISTAT: stat_clr = wr_bits;
            REG_IMASK: mask_d = (mask_q & ~wr_mask) | wr_bits;
`else
            REG_ISTAT: ;
            REG_IMASK: ;
`endif
            default:   bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_RESP: begin
        if (s.S_BREADY) w_state_d = W_COLLECT;
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Read path: data is captured at the AR handshake, so a read coinciding
  // with a write commit returns the pre-write register value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_val    = '0;
    rd_resp   = RESP_OKAY;
    ar_rdy    = !areset && (r_state_q == R_IDLE);

    case (ar_addr[4:2])
      REG_OUT:   rd_val[GPIO_W-1:0] = out_q;
      REG_OE:    rd_val[GPIO_W-1:0] = oe_q;
      REG_IN:    rd_val[GPIO_W-1:0] = sync_in;
      REG_SET:   ;
      REG_CLR:   ;
`ifdef GPIO_IRQ_EN
      REG_ISTAT: rd_val[GPIO_W-1:0] = stat_q;
      REG_IMASK: rd_val[GPIO_W-1:0] = mask_q;
`else
      REG_ISTAT: ;
      REG_IMASK: ;
`endif
      default:   rd_resp = RESP_SLVERR;
    endcase

    case (r_state_q)
      R_IDLE: begin
        if (s.S_ARVALID && ar_rdy) begin
          r_state_d = R_VALID;
          rdata_d   = rd_val;
          rresp_d   = rd_resp;
        end
      end
      R_VALID: begin
        if (s.S_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_COLLECT;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      out_q     <= '0;
      oe_q      <= '0;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
`ifdef GPIO_IRQ_EN
      prev_q    <= '0;
      stat_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef GPIO_IRQ_EN
      prev_q    <= prev_d;
      stat_q    <= stat_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign s.S_AWREADY = aw_rdy;
  assign s.S_WREADY  = w_rdy;
  assign s.S_BVALID  = !areset && (w_state_q == W_RESP);
  assign s.S_BRESP   = bresp_q;
  assign s.S_ARREADY = ar_rdy;
  assign s.S_RVALID  = !areset && (r_state_q == R_VALID);
  assign s.S_RDATA   = rdata_q;
  assign s.S_RRESP   = rresp_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;

  // Address bits outside [4:2], data above GPIO_W and upper strobe lanes
  // carry no function in this block.
  logic unused_bits;
  assign unused_bits = ^{aw_addr, ar_addr, s.S_WDATA, wr_mask32};

endmodule

// File: tb/tb_axil_gpio_slave.sv
module tb_axil_gpio_slave;
  import axil_gpio_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  axil_gpio_slave_if #(.ADDR_W(12)) bus();

  axil_gpio_slave #(.ADDR_W(12), .GPIO_W(16)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s        (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] b_q[$];
  rexp_t      r_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a B or R handshake is about to occur.
  always @(negedge aclk) begin
    if (!areset && bus.S_BVALID && bus.S_BREADY) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 32'(bus.S_BVALID), 32'd0);
      end else begin
        logic [1:0] eb;
        eb = b_q.pop_front();
        check("bresp", 32'(bus.S_BRESP), 32'(eb));
      end
    end
    if (!areset && bus.S_RVALID && bus.S_RREADY) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 32'(bus.S_RVALID), 32'd0);
      end else begin
        rexp_t er;
        er = r_q.pop_front();
        check("rdata", bus.S_RDATA, er.data);
        check("rresp", 32'(bus.S_RRESP), 32'(er.resp));
      end
    end
  end

  task automatic wait_drain();
    int cyc = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && cyc < 50) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("drain_pending", 32'(b_q.size() + r_q.size()), 32'd0);
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    b_q.push_back(exp);
    bus.S_AWADDR  = addr;
    bus.S_AWVALID = 1'b1;
    bus.S_WDATA   = data;
    bus.S_WSTRB   = strb;
    bus.S_WVALID  = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      if (bus.S_AWVALID && bus.S_AWREADY) aw_done = 1;
      if (bus.S_WVALID && bus.S_WREADY) w_done = 1;
      @(posedge aclk); #1;
      if (aw_done) bus.S_AWVALID = 1'b0;
      if (w_done) bus.S_WVALID = 1'b0;
      cyc++;
    end
    check("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
    wait_drain();
  endtask

  task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    bit done = 0;
    int cyc  = 0;
    r_q.push_back({exp_data, exp_resp});
    bus.S_ARADDR  = addr;
    bus.S_ARVALID = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge aclk);
      if (bus.S_ARVALID && bus.S_ARREADY) done = 1;
      @(posedge aclk); #1;
      if (done) bus.S_ARVALID = 1'b0;
      cyc++;
    end
    check("ar_accept", 32'(done), 32'd1);
    @(negedge aclk);
    check("rvalid_latency", 32'(bus.S_RVALID), 32'd1);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.S_AWADDR  = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_WDATA   = '0;
    bus.S_WSTRB   = '0;
    bus.S_WVALID  = 1'b0;
    bus.S_BREADY  = 1'b1;
    bus.S_ARADDR  = '0;
    bus.S_ARVALID = 1'b0;
    bus.S_RREADY  = 1'b1;
    gpio_in       = 16'hA5A5;

    // 1: reset state and IN read
    repeat (18) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 32'(bus.S_AWREADY), 32'd0);
    check("rst_wready",  32'(bus.S_WREADY),  32'd0);
    check("rst_arready", 32'(bus.S_ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.S_BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.S_RVALID),  32'd0);
    check("rst_bresp",   32'(bus.S_BRESP),   32'd0);
    check("rst_rresp",   32'(bus.S_RRESP),   32'd0);
    check("rst_rdata",   bus.S_RDATA,        32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_gpio_oe",  32'(gpio_oe),  32'd0);
    check("rst_irq",      32'(irq),      32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    axi_read(12'h008, 32'h0000A5A5, RESP_OKAY);

    // 2: AW then W three cycles later, B held off
    bus.S_BREADY = 1'b0;
    b_q.push_back(RESP_OKAY);
    bus.S_AWADDR  = 12'h000;
    bus.S_AWVALID = 1'b1;
    @(negedge aclk);
    check("t2_awready", 32'(bus.S_AWREADY), 32'd1);
    @(posedge aclk); #1;
    bus.S_AWVALID = 1'b0;
    @(negedge aclk);
    check("t2_awready_full", 32'(bus.S_AWREADY), 32'd0);
    check("t2_bvalid_n1",    32'(bus.S_BVALID),  32'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    bus.S_WDATA  = 32'h00001234;
    bus.S_WSTRB  = 4'h1;
    bus.S_WVALID = 1'b1;
    @(negedge aclk);
    check("t2_wready",    32'(bus.S_WREADY), 32'd1);
    check("t2_bvalid_n3", 32'(bus.S_BVALID), 32'd0);
    @(posedge aclk); #1;
    bus.S_WVALID = 1'b0;
    @(negedge aclk);
    check("t2_bvalid_n4", 32'(bus.S_BVALID), 32'd1);
    check("t2_gpio_out",  32'(gpio_out),     32'h0034);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("t2_bvalid_hold", 32'(bus.S_BVALID),  32'd1);
      check("t2_bresp_hold",  32'(bus.S_BRESP),   32'd0);
      check("t2_awready_hold", 32'(bus.S_AWREADY), 32'd0);
      check("t2_wready_hold",  32'(bus.S_WREADY),  32'd0);
    end
    @(posedge aclk); #1;
    bus.S_BREADY = 1'b1;
    wait_drain();

    // 3: OE, OUT, SET, CLR, strobe masking
    axi_write(12'h004, 32'h0000FFFF, 4'hF, RESP_OKAY);
    check("t3_oe", 32'(gpio_oe), 32'hFFFF);
    axi_write(12'h000, 32'h000000F0, 4'hF, RESP_OKAY);
    check("t3_out", 32'(gpio_out), 32'h00F0);
    axi_write(12'h00C, 32'h0000000F, 4'hF, RESP_OKAY);
    check("t3_set", 32'(gpio_out), 32'h00FF);
    axi_write(12'h010, 32'h000000F0, 4'hF, RESP_OKAY);
    check("t3_clr", 32'(gpio_out), 32'h000F);
    axi_write(12'h00C, 32'h0000FF00, 4'h1, RESP_OKAY);
    check("t3_set_strb", 32'(gpio_out), 32'h000F);
    axi_read(12'h00C, 32'h0, RESP_OKAY);
    axi_read(12'h010, 32'h0, RESP_OKAY);
    axi_read(12'h000, 32'h0000000F, RESP_OKAY);

    // 4: unmapped offset, write to IN, address aliasing
    axi_read(12'h01C, 32'h0, RESP_SLVERR);
    axi_write(12'h01C, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    check("t4_out_kept", 32'(gpio_out), 32'h000F);
    check("t4_oe_kept",  32'(gpio_oe),  32'hFFFF);
    axi_write(12'h008, 32'h00000000, 4'hF, RESP_OKAY);
    axi_read(12'h008, 32'h0000A5A5, RESP_OKAY);
    axi_read(12'h020, 32'h0000000F, RESP_OKAY);

    // 5: interrupt behaviour
`ifdef GPIO_IRQ_EN
    axi_write(12'h014, 32'h0000FFFF, 4'hF, RESP_OKAY);
    axi_write(12'h018, 32'h00000001, 4'hF, RESP_OKAY);
    @(posedge aclk); #1;
    check("t5_irq_idle", 32'(irq), 32'd0);
    gpio_in = 16'hA5A4;
    repeat (5) @(posedge aclk);
    #1;
    check("t5_irq_set", 32'(irq), 32'd1);
    axi_read(12'h014, 32'h00000001, RESP_OKAY);
    axi_write(12'h014, 32'h00000001, 4'hF, RESP_OKAY);
    @(posedge aclk); #1;
    check("t5_irq_clr", 32'(irq), 32'd0);
    gpio_in = 16'hA5A6;
    repeat (5) @(posedge aclk);
    #1;
    axi_read(12'h014, 32'h00000002, RESP_OKAY);
    check("t5_irq_masked", 32'(irq), 32'd0);
    axi_read(12'h018, 32'h00000001, RESP_OKAY);
`else
    axi_write(12'h018, 32'h0000FFFF, 4'hF, RESP_OKAY);
    axi_write(12'h014, 32'h0000FFFF, 4'hF, RESP_OKAY);
    gpio_in = 16'hA5A4;
    repeat (5) @(posedge aclk);
    #1;
    check("t5_irq_off", 32'(irq), 32'd0);
    axi_read(12'h014, 32'h0, RESP_OKAY);
    axi_read(12'h018, 32'h0, RESP_OKAY);
`endif

    // 6: reset while B and R are both pending
    bus.S_BREADY  = 1'b0;
    bus.S_RREADY  = 1'b0;
    bus.S_AWADDR  = 12'h000;
    bus.S_WDATA   = 32'h0000BEEF;
    bus.S_WSTRB   = 4'hF;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID  = 1'b1;
    bus.S_ARADDR  = 12'h004;
    bus.S_ARVALID = 1'b1;
    @(posedge aclk); #1;
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    bus.S_ARVALID = 1'b0;
    @(negedge aclk);
    check("t6_bvalid_pre", 32'(bus.S_BVALID), 32'd1);
    check("t6_rvalid_pre", 32'(bus.S_RVALID), 32'd1);
    check("t6_out_pre",    32'(gpio_out),     32'hBEEF);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("t6_bvalid_post", 32'(bus.S_BVALID), 32'd0);
    check("t6_rvalid_post", 32'(bus.S_RVALID), 32'd0);
    check("t6_out_post",    32'(gpio_out),     32'h0000);
    check("t6_oe_post",     32'(gpio_oe),      32'h0000);
    @(posedge aclk); #1;
    bus.S_BREADY = 1'b1;
    bus.S_RREADY = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    axi_write(12'h000, 32'h00000055, 4'hF, RESP_OKAY);
    check("t6_out_fresh", 32'(gpio_out), 32'h0055);
    axi_read(12'h004, 32'h0, RESP_OKAY);

    repeat (3) @(posedge aclk);
    #1;
    check("final_queues", 32'(b_q.size() + r_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
